// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response and memory-bus signals of the memory
// access sequencer, bundled as one interface.
//   master : the sequencer itself (takes requests, drives the memory strobes)
//   slave  : its environment (control unit / data register plus the memory)
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
) ();
  // control unit / data register side
  logic              rdReq;
  logic              wrReq;
  logic [ADDR_W-1:0] addrIn;
  logic [15:0]       dWriteIn;
  logic [15:0]       dReadOut;
  logic              mdrLoad;
  logic              done;
  logic              busy;
  logic              busErr;
  // external memory side
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWData;
  logic [15:0]       memRData;
  logic              memCs;
  logic              memWe;
  logic              memAck;

  modport master (
    input  rdReq, wrReq, addrIn, dWriteIn, memRData, memAck,
    output dReadOut, mdrLoad, done, busy, busErr,
    output memAddr, memWData, memCs, memWe
  );

  modport slave (
    output rdReq, wrReq, addrIn, dWriteIn, memRData, memAck,
    input  dReadOut, mdrLoad, done, busy, busErr,
    input  memAddr, memWData, memCs, memWe
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request memory access sequencer.
// IDLE -> ACCESS (strobes, wait states, ack) -> HOLD (data setup) -> DONE.
// Every output is a flop loaded from its next-state value.
// Optional feature: define MEM_TIMEOUT_EN to bound ACCESS at TIMEOUT cycles
// and report the expiry on the sticky busErr flag.
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_ctrl_if.master  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] WAIT_LIM    = 8'(WAIT_STATES);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       d_read_q, d_read_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mdr_load_q, mdr_load_d;

  // counter + 1 in nine bits: bit 8 flags saturation, and comparing cnt+1
  // keeps the wait/timeout tests meaningful even for zero limits
  logic [8:0]        cnt_inc_s;
  logic              wait_met_s;
  logic              ack_exit_s;
  logic              timed_out_s;

  assign cnt_inc_s  = {1'b0, cnt_q} + 9'd1;
  assign wait_met_s = (cnt_inc_s > {1'b0, WAIT_LIM});
  assign ack_exit_s = wait_met_s && bus.memAck;

`ifdef MEM_TIMEOUT_EN
  assign timed_out_s = (cnt_inc_s >= {1'b0, TIMEOUT_LIM});
`else
  // no access limit: ACCESS waits for memAck indefinitely
  assign timed_out_s = 1'b0;
  logic timeout_lim_unused;
  assign timeout_lim_unused = ^TIMEOUT_LIM;
`endif

  // sequencer next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_read_d    = d_read_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rdReq || bus.wrReq) begin
          state_d    = ST_ACCESS;
          op_wr_d    = bus.wrReq;        // write wins a simultaneous request
          mem_addr_d = bus.addrIn;
          cnt_d      = 8'd0;
          bus_err_d  = 1'b0;
          if (bus.wrReq) begin
            mem_wdata_d = bus.dWriteIn;
          end else begin
            mem_wdata_d = mem_wdata_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_inc_s[8]) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_inc_s[7:0];
        end
        if (ack_exit_s) begin
          state_d = ST_HOLD;
          if (!op_wr_q) begin
            d_read_d = bus.memRData;
          end else begin
            d_read_d = d_read_q;
          end
        end else if (timed_out_s) begin
          state_d   = ST_HOLD;
          bus_err_d = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_HOLD: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // output flops follow the next state so strobes line up with the state
  always_comb begin
    mem_cs_d   = (state_d == ST_ACCESS);
    mem_we_d   = (state_d == ST_ACCESS) && op_wr_d;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    mdr_load_d = (state_q == ST_HOLD) && !op_wr_q && !bus_err_q;
  end

  // state, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      op_wr_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
      d_read_q    <= 16'd0;
      bus_err_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mdr_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      d_read_q    <= d_read_d;
      bus_err_q   <= bus_err_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mdr_load_q  <= mdr_load_d;
    end
  end

  assign bus.dReadOut = d_read_q;
  assign bus.mdrLoad  = mdr_load_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.busErr   = bus_err_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWData = mem_wdata_q;
  assign bus.memCs    = mem_cs_q;
  assign bus.memWe    = mem_we_q;

endmodule
